// File: rtl/pin_safe_pkg.sv
// Shared definitions for the pin_safe combination lock: state encodings, segment codes,
// counter control codes and the BCD-to-7-segment decoder. PIN_SAFE_LOCKOUT_EN is handled in pin_safe.sv.
package pin_safe_pkg;

  localparam logic [2:0] PIN_SETUP = 3'd0;
  localparam logic [2:0] LOCKED    = 3'd1;
  localparam logic [2:0] CHECK     = 3'd2;
  localparam logic [2:0] UNLOCKED  = 3'd3;
  localparam logic [2:0] LOCKOUT   = 3'd4;

  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    REG_CTRL_HOLD = 2'd0,
    REG_CTRL_INC  = 2'd1,
    REG_CTRL_CLR  = 2'd2
  } reg_ctrl_e;

  // Active-low segments plus DP; anything outside 0..9 blanks the display.
  function automatic logic [7:0] seven_seg(input logic [3:0] d);
    logic [7:0] seg;
    case (d)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/pin_safe_shift_register.sv
// Shift register of DEPTH entries, WIDTH bits each. New data enters at the top entry
// (DEPTH-1) and older entries move toward entry 0; clear has priority over shift.
module pin_shift_register #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   sync_reset,
  input  logic                   shift_en,
  input  logic [WIDTH-1:0]       shift_in,
  input  logic                   clear,
  output logic [WIDTH*DEPTH-1:0] data_out
);

  logic [WIDTH*DEPTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = '0;
    end else if (shift_en) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        data_d[i*WIDTH +: WIDTH] = data_q[(i+1)*WIDTH +: WIDTH];
      end
      data_d[(DEPTH-1)*WIDTH +: WIDTH] = shift_in;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/pin_safe.sv
// Parametrised combination-lock controller driving a 7-segment display.
// Define PIN_SAFE_LOCKOUT_EN to enable the wrong-attempt lockout state.
module pin_safe
  import pin_safe_pkg::*;
#(
  parameter int PIN_DIGITS     = 3,
  parameter int DISPLAY_PERIOD = 100_000_000,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic       short_button_push,
  input  logic       long_button_push,
  input  logic [3:0] digit,
  output logic [7:0] seven_seg_output,
  output logic       unlocked,
  output logic       locked_out
);

  localparam int PW = 4 * PIN_DIGITS;
  localparam int DW = (DISPLAY_PERIOD > 1) ? $clog2(DISPLAY_PERIOD) : 1;
  localparam int IW = (PIN_DIGITS > 1) ? $clog2(PIN_DIGITS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DISPLAY_PERIOD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(PIN_DIGITS - 1);

  if (PIN_DIGITS < 1 || DISPLAY_PERIOD < 1 || MAX_ATTEMPTS < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_params
    $error("pin_safe: all parameters must be at least 1");
  end

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic          unlocked_q, unlocked_d;
  reg_ctrl_e     dwell_ctrl, idx_ctrl;

  logic          saved_shift, entered_shift, entered_clear;
  logic [PW-1:0] saved_pin, entered_pin;
  logic [3:0]    shown_digit;
  logic          digit_ok;

`ifdef PIN_SAFE_LOCKOUT_EN
  localparam int FW = $clog2(MAX_ATTEMPTS + 1);
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_ATTEMPTS - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          locked_out_q, locked_out_d;
  reg_ctrl_e     fail_ctrl, lock_ctrl;
`endif

  assign digit_ok = (digit <= 4'd9);

  pin_shift_register #(.WIDTH(4), .DEPTH(PIN_DIGITS)) u_saved_pin (
    .clk        (clk),
    .sync_reset (sync_reset),
    .shift_en   (saved_shift),
    .shift_in   (digit),
    .clear      (1'b0),
    .data_out   (saved_pin)
  );

  pin_shift_register #(.WIDTH(4), .DEPTH(PIN_DIGITS)) u_entered_pin (
    .clk        (clk),
    .sync_reset (sync_reset),
    .shift_en   (entered_shift),
    .shift_in   (digit),
    .clear      (entered_clear),
    .data_out   (entered_pin)
  );

  // Long push is always examined first so a simultaneous short push is dropped.
  always_comb begin
    state_d       = state_q;
    saved_shift   = 1'b0;
    entered_shift = 1'b0;
    entered_clear = 1'b0;
    dwell_ctrl    = REG_CTRL_HOLD;
    idx_ctrl      = REG_CTRL_HOLD;
`ifdef PIN_SAFE_LOCKOUT_EN
    fail_ctrl     = REG_CTRL_HOLD;
    lock_ctrl     = REG_CTRL_HOLD;
`endif
    case (state_q)
      PIN_SETUP: begin
        if (long_button_push) begin
          state_d       = LOCKED;
          entered_clear = 1'b1;
        end else if (short_button_push && digit_ok) begin
          saved_shift = 1'b1;
        end
      end
      LOCKED: begin
        if (long_button_push) begin
          state_d = CHECK;
        end else if (short_button_push && digit_ok) begin
          entered_shift = 1'b1;
        end
      end
      CHECK: begin
        if (entered_pin == saved_pin) begin
          state_d = UNLOCKED;
`ifdef PIN_SAFE_LOCKOUT_EN
          fail_ctrl = REG_CTRL_CLR;
`endif
        end else begin
          state_d       = LOCKED;
          entered_clear = 1'b1;
`ifdef PIN_SAFE_LOCKOUT_EN
          fail_ctrl = REG_CTRL_INC;
          if (fail_q == FAIL_LAST) begin
            state_d   = LOCKOUT;
            lock_ctrl = REG_CTRL_CLR;
          end
`endif
        end
      end
      UNLOCKED: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_ctrl = REG_CTRL_CLR;
          idx_ctrl   = (idx_q == IDX_LAST) ? REG_CTRL_CLR : REG_CTRL_INC;
        end else begin
          dwell_ctrl = REG_CTRL_INC;
        end
        if (long_button_push) begin
          state_d       = LOCKED;
          entered_clear = 1'b1;
          dwell_ctrl    = REG_CTRL_CLR;
          idx_ctrl      = REG_CTRL_CLR;
        end else if (short_button_push) begin
          state_d    = PIN_SETUP;
          dwell_ctrl = REG_CTRL_CLR;
          idx_ctrl   = REG_CTRL_CLR;
        end
      end
`ifdef PIN_SAFE_LOCKOUT_EN
      LOCKOUT: begin
        if (lock_q == LOCK_LAST) begin
          state_d       = LOCKED;
          lock_ctrl     = REG_CTRL_CLR;
          fail_ctrl     = REG_CTRL_CLR;
          entered_clear = 1'b1;
        end else begin
          lock_ctrl = REG_CTRL_INC;
        end
      end
`endif
      default: state_d = PIN_SETUP;
    endcase
  end

  always_comb begin
    dwell_d = dwell_q;
    case (dwell_ctrl)
      REG_CTRL_INC: dwell_d = dwell_q + DW'(1);
      REG_CTRL_CLR: dwell_d = '0;
      default:      dwell_d = dwell_q;
    endcase
    idx_d = idx_q;
    case (idx_ctrl)
      REG_CTRL_INC: idx_d = idx_q + IW'(1);
      REG_CTRL_CLR: idx_d = '0;
      default:      idx_d = idx_q;
    endcase
  end

  // Setup shows the most recent digit; unlocked walks through the saved PIN.
  always_comb begin
    shown_digit = saved_pin[PW-1 -: 4];
    if (state_q == UNLOCKED) begin
      for (int i = 0; i < PIN_DIGITS; i++) begin
        if (idx_q == IW'(i)) shown_digit = saved_pin[i*4 +: 4];
      end
    end
  end

  always_comb begin
    case (state_q)
      PIN_SETUP, UNLOCKED: seg_d = seven_seg(shown_digit);
      LOCKED, CHECK:       seg_d = SEG_L;
`ifdef PIN_SAFE_LOCKOUT_EN
      LOCKOUT:             seg_d = SEG_DASH;
`endif
      default:             seg_d = SEG_BLANK;
    endcase
    unlocked_d = (state_q == UNLOCKED);
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q    <= PIN_SETUP;
      dwell_q    <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      unlocked_q <= unlocked_d;
    end
  end

`ifdef PIN_SAFE_LOCKOUT_EN
  always_comb begin
    fail_d = fail_q;
    case (fail_ctrl)
      REG_CTRL_INC: fail_d = fail_q + FW'(1);
      REG_CTRL_CLR: fail_d = '0;
      default:      fail_d = fail_q;
    endcase
    lock_d = lock_q;
    case (lock_ctrl)
      REG_CTRL_INC: lock_d = lock_q + LW'(1);
      REG_CTRL_CLR: lock_d = '0;
      default:      lock_d = lock_q;
    endcase
    locked_out_d = (state_q == LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      fail_q       <= '0;
      lock_q       <= '0;
      locked_out_q <= 1'b0;
    end else begin
      fail_q       <= fail_d;
      lock_q       <= lock_d;
      locked_out_q <= locked_out_d;
    end
  end

  assign locked_out = locked_out_q;
`else
  assign locked_out = 1'b0;
`endif

  assign seven_seg_output = seg_q;
  assign unlocked         = unlocked_q;

endmodule

// File: tb/tb_pin_safe.sv
// Bench for pin_safe: directed scenarios with fixed expectations, then randomized pushes
// checked every cycle against a queue-based model of the lock. Honours PIN_SAFE_LOCKOUT_EN.
module tb_pin_safe;

  localparam int N  = 3;
  localparam int DP = 4;
  localparam int MA = 2;
  localparam int LC = 8;

  localparam int M_SETUP   = 0;
  localparam int M_LOCKED  = 1;
  localparam int M_CHECK   = 2;
  localparam int M_OPEN    = 3;
  localparam int M_LOCKOUT = 4;

  logic       clk = 1'b0;
  logic       sync_reset = 1'b0;
  logic       short_button_push = 1'b0;
  logic       long_button_push = 1'b0;
  logic [3:0] digit = 4'd0;
  logic [7:0] seven_seg_output;
  logic       unlocked;
  logic       locked_out;

  int total = 0;
  int bad   = 0;

  pin_safe #(
    .PIN_DIGITS(N), .DISPLAY_PERIOD(DP), .MAX_ATTEMPTS(MA), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk               (clk),
    .sync_reset        (sync_reset),
    .short_button_push (short_button_push),
    .long_button_push  (long_button_push),
    .digit             (digit),
    .seven_seg_output  (seven_seg_output),
    .unlocked          (unlocked),
    .locked_out        (locked_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_mode;
  int         m_saved[$];
  int         m_entered[$];
  int         m_dwell, m_idx, m_fails, m_lock;
  logic [7:0] exp_seg;
  logic       exp_unl, exp_lo;
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic logic [7:0] seg_of(input int d);
    return (d >= 0 && d <= 9) ? seg_tab[d] : 8'hFF;
  endfunction

  task automatic model_clear_entered();
    m_entered = {};
    repeat (N) m_entered.push_back(0);
  endtask

  task automatic model_reset();
    m_mode = M_SETUP;
    m_saved = {};
    repeat (N) m_saved.push_back(0);
    model_clear_entered();
    m_dwell = 0; m_idx = 0; m_fails = 0; m_lock = 0;
  endtask

  function automatic bit model_match();
    for (int i = 0; i < N; i++) if (m_saved[i] != m_entered[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_outputs();
    exp_unl = (m_mode == M_OPEN);
    exp_lo  = (m_mode == M_LOCKOUT);
    case (m_mode)
      M_SETUP:   exp_seg = seg_of(m_saved[N-1]);
      M_OPEN:    exp_seg = seg_of(m_saved[m_idx]);
      M_LOCKOUT: exp_seg = 8'hBF;
      default:   exp_seg = 8'hC7;
    endcase
  endtask

  task automatic model_step(input logic r, input logic s, input logic l, input logic [3:0] d);
    if (r) begin
      model_reset();
    end else begin
      case (m_mode)
        M_SETUP: begin
          if (l) begin
            m_mode = M_LOCKED;
            model_clear_entered();
          end else if (s && d <= 9) begin
            m_saved.delete(0);
            m_saved.push_back(int'(d));
          end
        end
        M_LOCKED: begin
          if (l) m_mode = M_CHECK;
          else if (s && d <= 9) begin
            m_entered.delete(0);
            m_entered.push_back(int'(d));
          end
        end
        M_CHECK: begin
          if (model_match()) begin
            m_mode = M_OPEN; m_fails = 0; m_dwell = 0; m_idx = 0;
          end else begin
            m_fails++;
            model_clear_entered();
            m_mode = M_LOCKED;
`ifdef PIN_SAFE_LOCKOUT_EN
            if (m_fails == MA) begin
              m_mode = M_LOCKOUT;
              m_lock = 0;
            end
`endif
          end
        end
        M_OPEN: begin
          if (l) begin
            m_mode = M_LOCKED;
            model_clear_entered();
          end else if (s) begin
            m_mode = M_SETUP;
          end else begin
            m_dwell++;
            if (m_dwell == DP) begin
              m_dwell = 0;
              m_idx = (m_idx + 1) % N;
            end
          end
        end
        default: begin
          m_lock++;
          if (m_lock == LC) begin
            m_mode = M_LOCKED; m_fails = 0;
            model_clear_entered();
          end
        end
      endcase
    end
  endtask

  // ---------------- drivers ----------------
  // Inputs are applied 1 time unit after an edge; outputs are read 1 unit after the next edge.
  task automatic drive_cycle(input logic s, input logic l, input logic [3:0] d, input logic r);
    sync_reset = r; short_button_push = s; long_button_push = l; digit = d;
    if (r) begin
      exp_seg = 8'hFF; exp_unl = 1'b0; exp_lo = 1'b0;
    end else begin
      model_outputs();
    end
    @(posedge clk);
    model_step(r, s, l, d);
    #1;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic press(input logic [3:0] d);
    drive_cycle(1'b1, 1'b0, d, 1'b0);
    idle();
  endtask

  task automatic long_push();
    drive_cycle(1'b0, 1'b1, 4'd0, 1'b0);
  endtask

  task automatic submit_and_settle(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    press(a); press(b); press(c);
    long_push(); idle(); idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_cycle(1'b0, 1'b0, 4'd0, 1'b1);
    drive_cycle(1'b0, 1'b0, 4'd0, 1'b1);
    total++; if (seven_seg_output !== 8'hFF) begin bad++; $display("FAIL reset_seg: got=%h want=%h", seven_seg_output, 8'hFF); end
    total++; if (unlocked !== 1'b0) begin bad++; $display("FAIL reset_unlocked: got=%b want=0", unlocked); end
    total++; if (locked_out !== 1'b0) begin bad++; $display("FAIL reset_locked_out: got=%b want=0", locked_out); end
    idle();
    total++; if (seven_seg_output !== 8'hC0) begin bad++; $display("FAIL reset_pin_zero: got=%h want=%h", seven_seg_output, 8'hC0); end
  endtask

  task automatic test_setup_entry();
    logic [7:0] want [3] = '{8'hF9, 8'hA4, 8'hB0};
    for (int i = 0; i < 3; i++) begin
      press(4'(i + 1));
      total++; if (seven_seg_output !== want[i]) begin bad++; $display("FAIL setup_digit%0d: got=%h want=%h", i + 1, seven_seg_output, want[i]); end
    end
    long_push(); idle();
    total++; if (seven_seg_output !== 8'hC7 || unlocked !== 1'b0) begin bad++; $display("FAIL setup_to_locked: seg=%h unl=%b want C7/0", seven_seg_output, unlocked); end
  endtask

  task automatic test_unlock_cycle();
    logic [7:0] want [3] = '{8'hF9, 8'hA4, 8'hB0};
    press(4'd1); press(4'd2); press(4'd3);
    long_push(); idle();
    total++; if (unlocked !== 1'b0) begin bad++; $display("FAIL unlock_early: got=%b want=0", unlocked); end
    for (int k = 0; k <= 12; k++) begin
      idle();
      total++;
      if (unlocked !== 1'b1 || seven_seg_output !== want[(k / DP) % N]) begin
        bad++; $display("FAIL unlock_dwell k=%0d: seg=%h unl=%b want=%h/1", k, seven_seg_output, unlocked, want[(k / DP) % N]);
      end
    end
    long_push(); idle();
    total++; if (unlocked !== 1'b0 || seven_seg_output !== 8'hC7) begin bad++; $display("FAIL relock: seg=%h unl=%b want C7/0", seven_seg_output, unlocked); end
  endtask

  task automatic test_wrong_pin();
    submit_and_settle(4'd1, 4'd2, 4'd4);
    total++; if (unlocked !== 1'b0 || seven_seg_output !== 8'hC7) begin bad++; $display("FAIL wrong_pin: seg=%h unl=%b want C7/0", seven_seg_output, unlocked); end
    submit_and_settle(4'd1, 4'd2, 4'd3);
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL right_after_wrong: got=%b want=1", unlocked); end
    long_push(); idle();
  endtask

  task automatic test_invalid_and_priority();
    drive_cycle(1'b0, 1'b0, 4'd0, 1'b1);
    press(4'd5);
    total++; if (seven_seg_output !== 8'h92) begin bad++; $display("FAIL setup_5: got=%h want=92", seven_seg_output); end
    drive_cycle(1'b1, 1'b0, 4'hA, 1'b0); idle();
    total++; if (seven_seg_output !== 8'h92) begin bad++; $display("FAIL invalid_digit: got=%h want=92", seven_seg_output); end
    drive_cycle(1'b1, 1'b1, 4'd7, 1'b0); idle();
    total++; if (seven_seg_output !== 8'hC7) begin bad++; $display("FAIL short_long_same: got=%h want=C7", seven_seg_output); end
    submit_and_settle(4'd0, 4'd0, 4'd5);
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL pin_005_unlock: got=%b want=1", unlocked); end
    long_push(); idle();
  endtask

  task automatic test_lockout();
    submit_and_settle(4'd9, 4'd9, 4'd9);
    total++; if (seven_seg_output !== 8'hC7 || locked_out !== 1'b0) begin bad++; $display("FAIL first_wrong: seg=%h lo=%b want C7/0", seven_seg_output, locked_out); end
`ifdef PIN_SAFE_LOCKOUT_EN
    begin
      logic       ls [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic       ll [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0] ld [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0};
      press(4'd9); press(4'd9); press(4'd9);
      long_push(); idle();
      for (int i = 0; i < LC; i++) begin
        drive_cycle(ls[i], ll[i], ld[i], 1'b0);
        total++;
        if (seven_seg_output !== 8'hBF || locked_out !== 1'b1 || unlocked !== 1'b0) begin
          bad++; $display("FAIL lockout_cycle%0d: seg=%h lo=%b unl=%b want BF/1/0", i, seven_seg_output, locked_out, unlocked);
        end
      end
      idle();
      total++; if (seven_seg_output !== 8'hC7 || locked_out !== 1'b0) begin bad++; $display("FAIL lockout_exit: seg=%h lo=%b want C7/0", seven_seg_output, locked_out); end
    end
`else
    submit_and_settle(4'd9, 4'd9, 4'd9);
    total++; if (seven_seg_output !== 8'hC7 || locked_out !== 1'b0) begin bad++; $display("FAIL second_wrong: seg=%h lo=%b want C7/0", seven_seg_output, locked_out); end
`endif
    submit_and_settle(4'd0, 4'd0, 4'd5);
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL unlock_after_fails: got=%b want=1", unlocked); end
  endtask

  task automatic test_reset_mid_dwell();
    idle(); idle();
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL mid_dwell_open: got=%b want=1", unlocked); end
    drive_cycle(1'b0, 1'b0, 4'd0, 1'b1);
    total++; if (seven_seg_output !== 8'hFF || unlocked !== 1'b0) begin bad++; $display("FAIL mid_dwell_reset: seg=%h unl=%b want FF/0", seven_seg_output, unlocked); end
    idle();
    total++; if (seven_seg_output !== 8'hC0) begin bad++; $display("FAIL reset_pin_lost: got=%h want=C0", seven_seg_output); end
    long_push(); idle(); long_push(); idle(); idle();
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL pin_000_unlock: got=%b want=1", unlocked); end
  endtask

  task automatic test_random();
    logic       r, s, l;
    logic [3:0] d;
    drive_cycle(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 99) < 30);
      l = ($urandom_range(0, 99) < 8);
      d = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 1));
      drive_cycle(s, l, d, r);
      total++;
      if (seven_seg_output !== exp_seg || unlocked !== exp_unl || locked_out !== exp_lo) begin
        bad++;
        if (bad < 20) $display("FAIL random cycle=%0d: seg=%h unl=%b lo=%b want %h/%b/%b",
                               i, seven_seg_output, unlocked, locked_out, exp_seg, exp_unl, exp_lo);
      end
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_setup_entry();
    test_unlock_cycle();
    test_wrong_pin();
    test_invalid_and_priority();
    test_lockout();
    test_reset_mid_dwell();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
